data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder that sits on the datapath side of the memRead/memWrite control signals produced by the instruction decoder.
- Services one load or store at a time, with a parameterised access latency.
- Holds the pipeline with a stall output while an access is in flight, then pulses done for exactly one cycle when the access completes.
- Word-addressed, 16-bit data, single-port synchronous storage.

Parameters:
DATA_W, 16, data word width
ADDR_W, 8, address width; memory depth is 2**ADDR_W words
LATENCY, 2, cycles from request acceptance to completion; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
memRead  input  1  load request from control decode
memWrite  input  1  store request from control decode
addr  input  ADDR_W  word address, sampled on acceptance
wrData  input  DATA_W  store data, sampled on acceptance
rdData  output  DATA_W  load result, valid from the done cycle and held until the next load completes
stall  output  1  freeze request to pipeline while access is in flight
done  output  1  one-cycle completion pulse
reqError  output  1  sticky flag: memRead and memWrite were both high at acceptance

Behaviour:
- Reset, synchronous and active-high: the clock is clk, the reset is rst, and reset is sampled only on the rising edge of clk.
- Reset values: state=IDLE, counter=0, rdData=0, stall=0, done=0, reqError=0.
- Memory contents are not cleared by reset.
- States:
  - IDLE: no access in flight.
  - BUSY: counting down latency.
  - RESP: completion cycle.
- Acceptance:
  - In IDLE, (memRead|memWrite)=1 latches addr, wrData and op type.
  - If both are high, the op is a store and reqError is set. reqError is cleared only by rst.
- Stall timing:
  - stall is combinational and goes high in the acceptance cycle.
  - stall stays high through every BUSY cycle.
  - stall is low in RESP and in IDLE when there is no request.
- Latency, for acceptance at cycle T:
  - LATENCY=1: next cycle is RESP.
  - LATENCY>1: BUSY for LATENCY-1 cycles, then RESP.
  - In both cases RESP occurs at T+LATENCY and stall is high for cycles T..T+LATENCY-1.
- Counter: loaded with LATENCY-1 at acceptance and decremented in BUSY. BUSY moves to RESP when the counter reaches 1.
- RESP cycle:
  - done=1.
  - Loads: rdData is updated at the RESP edge from mem[latched addr], so the value is visible during the RESP cycle.
  - Stores: mem[latched addr] is written with the latched data at the RESP edge; rdData is unchanged.
- After RESP: always returns to IDLE.
  - A request still asserted in the cycle after RESP is a new request, which gives back-to-back accesses one idle-free turnaround.
- Inputs in BUSY and RESP are ignored; the requester must hold them stable while stall=1, but the block does not depend on this.
- Addressing: addresses wrap naturally modulo 2**ADDR_W; there is no out-of-range condition.
- Load after store to the same address: the load returns the newly written data, since the store commits before the load is accepted.
- Reset mid-operation: a pending store is discarded (memory unchanged), a pending load is discarded (rdData forced to 0), and the state returns to IDLE with stall=0 in the following cycle.
- done is never asserted in two consecutive cycles.

Test Plan:
- Reset, then store 0xBEEF to addr 0x12 with LATENCY=2 → stall high for 2 cycles, done pulse in cycle 3. Then load addr 0x12 → rdData=0xBEEF in its done cycle, stall high for exactly 2 cycles.
- LATENCY=1: back-to-back loads of addr 0x00 and 0x01, preloaded with 0x1111/0x2222 → done in alternating cycles, rdData=0x1111 then 0x2222, stall high only in acceptance cycles.
- memRead=memWrite=1, addr 0x05, wrData 0x0A0A → treated as store, reqError=1 and held. A later load of 0x05 returns 0x0A0A; reqError clears only on rst.
- Store 0x1234 to 0x40, assert rst during the BUSY cycle → stall=0 and done=0 next cycle, state IDLE. A subsequent load of 0x40 returns the pre-store value.
- Address wrap with ADDR_W=8: store 0x5555 to 0xFF, then load 0xFF → 0x5555; the neighbouring word at 0x00 is unchanged.
- Change addr/wrData during BUSY → the completed access uses the originally latched values; done pulses exactly once per accepted request.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store in flight at a time, fixed latency,
// stall while busy, one-cycle done pulse, sticky request-conflict flag.
module data_mem_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              stall,
  output logic              done,
  output logic              reqError
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic req;
  logic accept;
  logic enter_resp;

  assign req        = memRead | memWrite;
  assign accept     = (state_q == S_IDLE) && req;
  assign enter_resp = (state_d == S_RESP);

  // Next-state, counter, request latch and load result.
  // The access completes on the edge entering RESP, using the *_d request
  // fields so a single-cycle latency sees the request being accepted now.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = addr;
          data_d = wrData;
          wr_d   = memWrite;
          cnt_d  = CNT_INIT;
          if (memRead && memWrite) begin
            err_d = 1'b1;
          end
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (enter_resp && !wr_d) begin
      rd_d = mem[addr_d];
    end
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Store commit; contents survive reset but a reset edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && wr_d) begin
      mem[addr_d] <= data_d;
    end
  end

  assign stall    = accept || (state_q == S_BUSY);
  assign done     = (state_q == S_RESP);
  assign rdData   = rd_q;
  assign reqError = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 1), a
// cycle-accurate reference model checked every cycle, plus directed checks.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        mr [2];
  logic        mw [2];
  logic [7:0]  ad [2];
  logic [15:0] wd [2];
  logic [15:0] rd [2];
  logic        st [2];
  logic        dn [2];
  logic        er [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;
  int lat_p [2] = '{2, 1};

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .memRead(mr[0]), .memWrite(mw[0]),
    .addr(ad[0]), .wrData(wd[0]), .rdData(rd[0]), .stall(st[0]),
    .done(dn[0]), .reqError(er[0])
  );

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .memRead(mr[1]), .memWrite(mw[1]),
    .addr(ad[1]), .wrData(wd[1]), .rdData(rd[1]), .stall(st[1]),
    .done(dn[1]), .reqError(er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // Reference model: a request accepted in cycle T owns cycles T..T+L,
  // stalls T..T+L-1 and completes (done, commit) in cycle T+L.
  bit          m_val  [2];
  int          m_t    [2];
  bit          m_wr   [2];
  logic [7:0]  m_a    [2];
  logic [15:0] m_d    [2];
  logic [15:0] m_rd   [2];
  bit          m_rdok [2];
  bit          m_err  [2];
  logic [15:0] mm     [2][256];
  bit          mk     [2][256];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_t[k] = 0; m_wr[k] = 0; m_a[k] = '0; m_d[k] = '0;
      m_rd[k] = '0; m_rdok[k] = 1; m_err[k] = 0;
      for (int i = 0; i < 256; i++) begin
        mm[k][i] = '0; mk[k][i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit idle, fly, resp, rq;
        idle = !m_val[k] || (cyc > m_t[k] + lat_p[k]);
        fly  = m_val[k] && (cyc >= m_t[k]) && (cyc < m_t[k] + lat_p[k]);
        resp = m_val[k] && (cyc == m_t[k] + lat_p[k]);
        rq   = mr[k] || mw[k];
        if (resp) begin
          if (m_wr[k]) begin
            mm[k][m_a[k]] = m_d[k];
            mk[k][m_a[k]] = 1;
          end else begin
            m_rd[k]   = mm[k][m_a[k]];
            m_rdok[k] = mk[k][m_a[k]];
          end
        end
        chk($sformatf("m%0d_stall", k), 32'(st[k]), 32'(fly || (idle && rq)));
        chk($sformatf("m%0d_done", k), 32'(dn[k]), 32'(resp));
        chk($sformatf("m%0d_err", k), 32'(er[k]), 32'(m_err[k]));
        if (m_rdok[k]) begin
          chk($sformatf("m%0d_rd", k), 32'(rd[k]), 32'(m_rd[k]));
        end
        if (idle && rq && !rst) begin
          m_val[k] = 1;
          m_t[k]   = cyc;
          m_wr[k]  = mw[k];
          m_a[k]   = ad[k];
          m_d[k]   = wd[k];
          if (mr[k] && mw[k]) m_err[k] = 1;
        end
        if (rst) begin
          m_val[k]  = 0;
          m_rd[k]   = '0;
          m_rdok[k] = 1;
          m_err[k]  = 0;
        end
      end
    end
  end

  // Issues one request at posedge+1 and waits (bounded) for its done pulse.
  task automatic do_req(input int k, input bit r, input bit w,
                        input logic [7:0] a, input logic [15:0] d,
                        input bit scr, output logic [15:0] rv,
                        output int lat, output int ns, output int dc);
    bit got;
    got = 0; rv = '0; lat = 0; ns = 0; dc = 0;
    mr[k] = r; mw[k] = w; ad[k] = a; wd[k] = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (st[k]) ns++;
      if (dn[k]) begin
        got = 1; rv = rd[k]; lat = i; dc = cyc;
      end
      @(posedge clk);
      #1;
      if (i == 0) begin
        mr[k] = 0; mw[k] = 0;
        if (scr) begin
          ad[k] = ~a; wd[k] = ~d;
        end
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL req_timeout k=%0d got=none want=done", k);
    end
  endtask

  logic [15:0] rv;
  int lat, ns, dc, dc1;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mr[k] = 0; mw[k] = 0; ad[k] = '0; wd[k] = '0;
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_stall_a", 32'(st[0]), 0);
    chk("rst_done_a", 32'(dn[0]), 0);
    chk("rst_rd_a", 32'(rd[0]), 0);
    chk("rst_err_b", 32'(er[1]), 0);
    @(posedge clk); #1;

    do_req(0, 0, 1, 8'h40, 16'h0404, 0, rv, lat, ns, dc);
    do_req(0, 0, 1, 8'h00, 16'h0A00, 0, rv, lat, ns, dc);
    do_req(1, 0, 1, 8'h00, 16'h1111, 0, rv, lat, ns, dc);
    do_req(1, 0, 1, 8'h01, 16'h2222, 0, rv, lat, ns, dc);

    do_req(0, 0, 1, 8'h12, 16'hBEEF, 0, rv, lat, ns, dc);
    chk("st12_lat", lat, 2);
    chk("st12_stall", ns, 2);
    do_req(0, 1, 0, 8'h12, 16'h0000, 0, rv, lat, ns, dc);
    chk("ld12_rd", 32'(rv), 32'hBEEF);
    chk("ld12_lat", lat, 2);
    chk("ld12_stall", ns, 2);

    do_req(1, 1, 0, 8'h00, 16'h0000, 0, rv, lat, ns, dc1);
    chk("l1_ld0_rd", 32'(rv), 32'h1111);
    chk("l1_ld0_stall", ns, 1);
    do_req(1, 1, 0, 8'h01, 16'h0000, 0, rv, lat, ns, dc);
    chk("l1_ld1_rd", 32'(rv), 32'h2222);
    chk("l1_ld1_lat", lat, 1);
    chk("l1_done_gap", dc - dc1, 2);

    do_req(0, 1, 1, 8'h05, 16'h0A0A, 0, rv, lat, ns, dc);
    @(negedge clk);
    chk("both_err", 32'(er[0]), 1);
    @(posedge clk); #1;
    do_req(0, 1, 0, 8'h05, 16'h0000, 0, rv, lat, ns, dc);
    chk("both_ld_rd", 32'(rv), 32'h0A0A);
    chk("both_err_held", 32'(er[0]), 1);

    do_req(0, 0, 1, 8'hFF, 16'h5555, 0, rv, lat, ns, dc);
    do_req(0, 1, 0, 8'hFF, 16'h0000, 0, rv, lat, ns, dc);
    chk("wrap_ff_rd", 32'(rv), 32'h5555);
    do_req(0, 1, 0, 8'h00, 16'h0000, 0, rv, lat, ns, dc);
    chk("wrap_00_rd", 32'(rv), 32'h0A00);

    do_req(0, 0, 1, 8'h30, 16'h7777, 1, rv, lat, ns, dc);
    chk("scr_st_lat", lat, 2);
    do_req(0, 1, 0, 8'h30, 16'h0000, 1, rv, lat, ns, dc);
    chk("scr_ld_rd", 32'(rv), 32'h7777);
    repeat (3) @(posedge clk);
    #1;

    mw[0] = 1; ad[0] = 8'h40; wd[0] = 16'h1234;
    @(posedge clk); #1;
    mw[0] = 0; rst = 1'b1;
    @(negedge clk);
    chk("rmid_busy_stall", 32'(st[0]), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_stall", 32'(st[0]), 0);
    chk("rmid_done", 32'(dn[0]), 0);
    chk("rmid_rd", 32'(rd[0]), 0);
    chk("rmid_err", 32'(er[0]), 0);
    @(posedge clk); #1;
    do_req(0, 1, 0, 8'h40, 16'h0000, 0, rv, lat, ns, dc);
    chk("rmid_ld40", 32'(rv), 32'h0404);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
